// File: rtl/pad_poll_scheduler.sv
// Polls two pads per frame on a shared transfer engine and latches logical P1/P2 button words.
// Define PAD_RESET_COMBO_EN to add the held-button reset-combo detector.
module pad_poll_scheduler #(
    parameter int PERIOD       = 8333,
    parameter int TIMEOUT      = 1024,
    parameter int DROP_COUNT   = 3,
    parameter int COMBO_FRAMES = 30
) (
    input  logic        clk,
    input  logic        n_reset,
    output logic        xfer_start,
    output logic        xfer_abort,
    output logic        port_sel,
    input  logic        xfer_done,
    input  logic        xfer_ok,
    input  logic [15:0] xfer_buttons,
    input  logic        pad_exchange,
    output logic [15:0] buttons_p1,
    output logic [15:0] buttons_p2,
    output logic        connect_p1,
    output logic        connect_p2,
    output logic        frame_tick,
    output logic        overrun,
    output logic        combo_reset
);

    localparam int PW = $clog2(PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(DROP_COUNT + 1);

    if (PERIOD < 2 || TIMEOUT < 1 || DROP_COUNT < 1 || COMBO_FRAMES < 1) begin : g_bad_params
        $error("pad_poll_scheduler: parameters out of range");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, LATCH} state_t;

    state_t              state;
    state_t              state_next;
    logic [PW-1:0]       period_cnt;
    logic [TW-1:0]       timeout_cnt;
    logic                cur_port;
    logic                exch_q;
    logic [1:0][15:0]    shadow_btn;
    logic [1:0]          shadow_con;
    logic [1:0][FW-1:0]  fail_cnt;

    logic                wrap;
    logic                timeout_hit;
    logic                xfer_end;
    logic                xfer_good;
    logic                xfer_fail;
    logic [15:0]         next_btn_p1;
    logic [15:0]         next_btn_p2;
    logic                next_con_p1;
    logic                next_con_p2;

    assign wrap        = (period_cnt == PW'(PERIOD - 1));
    assign timeout_hit = (timeout_cnt == TW'(TIMEOUT - 1));
    assign port_sel    = cur_port;
    assign xfer_good   = xfer_end && xfer_done && xfer_ok;
    assign xfer_fail   = xfer_end && !(xfer_done && xfer_ok);

    assign next_btn_p1 = exch_q ? shadow_btn[1] : shadow_btn[0];
    assign next_btn_p2 = exch_q ? shadow_btn[0] : shadow_btn[1];
    assign next_con_p1 = exch_q ? shadow_con[1] : shadow_con[0];
    assign next_con_p2 = exch_q ? shadow_con[0] : shadow_con[1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_next;
    end

    // A completion that coincides with the timeout wins, so no abort is issued for it.
    always_comb begin
        state_next = state;
        xfer_start = 1'b0;
        xfer_abort = 1'b0;
        xfer_end   = 1'b0;
        case (state)
            IDLE: begin
                if (wrap) state_next = START;
            end
            START: begin
                xfer_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (xfer_done) begin
                    xfer_end = 1'b1;
                end else if (timeout_hit) begin
                    xfer_abort = 1'b1;
                    xfer_end   = 1'b1;
                end
                if (xfer_end) state_next = cur_port ? LATCH : START;
            end
            LATCH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            period_cnt  <= '0;
            timeout_cnt <= '0;
            cur_port    <= 1'b0;
            exch_q      <= 1'b0;
        end else begin
            period_cnt <= wrap ? '0 : period_cnt + PW'(1);
            if (state == START)     timeout_cnt <= '0;
            else if (state == WAIT) timeout_cnt <= timeout_cnt + TW'(1);
            if (state == IDLE && wrap)                cur_port <= 1'b0;
            else if (xfer_end && !cur_port)           cur_port <= 1'b1;
            else if (state == LATCH)                  cur_port <= 1'b0;
            if (state == START && !cur_port) exch_q <= pad_exchange;
        end
    end

    // Failures below the drop threshold keep the last good button word.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shadow_btn <= {2{16'hFFFF}};
            shadow_con <= 2'b00;
            fail_cnt   <= '0;
        end else if (xfer_good) begin
            fail_cnt[cur_port]   <= '0;
            shadow_con[cur_port] <= 1'b1;
            shadow_btn[cur_port] <= xfer_buttons;
        end else if (xfer_fail) begin
            if (fail_cnt[cur_port] >= FW'(DROP_COUNT - 1)) begin
                fail_cnt[cur_port]   <= FW'(DROP_COUNT);
                shadow_con[cur_port] <= 1'b0;
                shadow_btn[cur_port] <= 16'hFFFF;
            end else begin
                fail_cnt[cur_port] <= fail_cnt[cur_port] + FW'(1);
            end
        end
    end

    // frame_tick is registered so it coincides with the newly latched outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            buttons_p1 <= 16'hFFFF;
            buttons_p2 <= 16'hFFFF;
            connect_p1 <= 1'b0;
            connect_p2 <= 1'b0;
            frame_tick <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_tick <= (state == LATCH);
            if (state == LATCH) begin
                buttons_p1 <= next_btn_p1;
                buttons_p2 <= next_btn_p2;
                connect_p1 <= next_con_p1;
                connect_p2 <= next_con_p2;
            end
            if (wrap && state != IDLE) overrun <= 1'b1;
        end
    end

`ifdef PAD_RESET_COMBO_EN
    localparam int CW = $clog2(COMBO_FRAMES + 1);
    logic [CW-1:0] combo_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            combo_cnt <= '0;
        end else if (state == LATCH) begin
            if (next_con_p1 && next_btn_p1[11:8] == 4'h0) begin
                if (combo_cnt != CW'(COMBO_FRAMES)) combo_cnt <= combo_cnt + CW'(1);
            end else begin
                combo_cnt <= '0;
            end
        end
    end

    assign combo_reset = (combo_cnt == CW'(COMBO_FRAMES));
`else
    assign combo_reset = 1'b0;
`endif

endmodule

// File: doc/pad_poll_scheduler.md
PAD_POLL_SCHEDULER -- requirements
Module: pad_poll_scheduler

Interface
REQ-001 Parameter PERIOD, default 8333, clk cycles between poll-frame starts (60 Hz at 500 kHz).
REQ-002 Parameter TIMEOUT, default 1024, max clk cycles waited for one transfer.
REQ-003 Parameter DROP_COUNT, default 3, consecutive failed transfers before a port reads as disconnected.
REQ-004 Parameter COMBO_FRAMES, default 30, frames the reset combo must be held.
REQ-005 Port clk  in  1  pad clock, 500 kHz; all logic on rising edge.
REQ-006 Port n_reset  in  1  asynchronous, active-low reset.
REQ-007 Port xfer_start  out  1  one-cycle pulse that starts a transfer on the shared pad engine.
REQ-008 Port xfer_abort  out  1  one-cycle pulse that cancels a timed-out transfer.
REQ-009 Port port_sel  out  1  physical pad addressed: 0 = P1 lines, 1 = P2 lines.
REQ-010 Port xfer_done  in  1  one-cycle pulse marking transfer complete.
REQ-011 Port xfer_ok  in  1  valid with xfer_done; 1 = pad answered with a valid ID.
REQ-012 Port xfer_buttons  in  16  active-low DUALSHOCK button word, valid with xfer_done.
REQ-013 Port pad_exchange  in  1  swap logical P1/P2.
REQ-014 Port buttons_p1, buttons_p2  out  16 each  logical active-low button words.
REQ-015 Port connect_p1, connect_p2  out  1 each  logical connection status.
REQ-016 Port frame_tick  out  1  one-cycle pulse when outputs update.
REQ-017 Port overrun  out  1  sticky flag: a frame start arrived while the previous frame was still running.
REQ-018 Port combo_reset  out  1  reset request from the pad button combo.

Function
REQ-019 The free-running period counter shall count 0..PERIOD-1 and wrap; a wrap while the FSM is in IDLE shall start a frame (go to START, port 0).
REQ-020 FSM states shall be IDLE, START, WAIT, LATCH.
REQ-021 START shall pulse xfer_start, drive port_sel = current port, clear the timeout counter, and go to WAIT the next cycle.
REQ-022 WAIT on xfer_done shall store xfer_buttons (if xfer_ok) into that port's shadow word, then go to START for port 1 or to LATCH after port 1.
REQ-023 WAIT with no xfer_done and timeout counter = TIMEOUT-1 shall pulse xfer_abort, count a failure, and advance like REQ-022; xfer_done in the same cycle wins, with no abort.
REQ-024 Per-port fail counter: xfer_ok clears it to 0 and sets the shadow connect; a failure increments it, saturating at DROP_COUNT; reaching DROP_COUNT clears the shadow connect and sets the shadow buttons to 16'hFFFF.
REQ-025 A failure below DROP_COUNT shall leave the shadow buttons unchanged.
REQ-026 pad_exchange shall be sampled in the frame's first START cycle and held for the frame.
REQ-027 LATCH shall copy both shadows to the outputs (swapped if the sampled exchange = 1), pulse frame_tick, and return to IDLE; the outputs shall change only here.
REQ-028 A period wrap outside IDLE shall set overrun and be dropped, not queued; overrun shall clear only on reset.
REQ-029 Latency from xfer_done to output update shall be at most 1 transfer + 2 cycles.

Reset
REQ-030 While n_reset = 0, any state shall go immediately to IDLE, including mid-transfer, and no abort pulse shall be issued.
REQ-031 Reset values: counters 0, port_sel 0, pulses 0, buttons 16'hFFFF, connect 0, overrun 0, combo_reset 0.
REQ-032 The first frame shall start at the first period wrap after reset release, PERIOD cycles later.

Configuration
REQ-033 With macro PAD_RESET_COMBO_EN defined, a frame counter shall increment at each LATCH where logical P1 is connected and buttons_p1[11:8] = 4'h0, saturating at COMBO_FRAMES.
REQ-034 With the macro defined, any other LATCH shall clear that counter; combo_reset = 1 whenever the counter equals COMBO_FRAMES.
REQ-035 Without the macro, combo_reset shall be constant 0 and the counter shall not exist.

Verification
REQ-036 PERIOD=100, both pads answer ok with 16'hFFFE/16'hBFFF -> xfer_start at cycles 100, port 0 then 1; frame_tick set; buttons_p1=16'hFFFE, buttons_p2=16'hBFFF, both connected.
REQ-037 P2 silent, TIMEOUT=16 -> xfer_abort 16 cycles after its start; connect_p2 drops at the 3rd frame; buttons_p2=16'hFFFF.
REQ-038 pad_exchange toggled mid-frame -> outputs swap only at the next frame's LATCH.
REQ-039 TIMEOUT > PERIOD with silent pads -> overrun=1, frame starts skipped, no back-to-back frames.
REQ-040 n_reset pulsed during WAIT -> all outputs at reset values, no abort, restart after PERIOD cycles.
REQ-041 With PAD_RESET_COMBO_EN, COMBO_FRAMES=4, P1 reports 16'hF0FF -> combo_reset rises at the 4th frame_tick and falls at the first frame with 16'hFFFF.
